// File: rtl/i8259_pic.sv
// Simplified 8-input priority interrupt controller: edge-latched requests, mask,
// in-service nesting with fixed priority (bit 0 highest), and a vectored acknowledge.
module i8259_pic #(
    parameter logic [4:0] VEC_BASE = 5'b00100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs,
    input  logic       rd,
    input  logic       wr,
    input  logic [1:0] a,
    input  logic [7:0] idata,
    output logic [7:0] odata,
    input  logic [7:0] irq,
    input  logic       inta,
    output logic       intr,
    output logic [7:0] ivec,
    output logic       ivec_valid
);

    logic [7:0] irr, isr, imr, last_irq;
    logic [4:0] base;
    logic [1:0] rsel;

    logic [7:0] isr_low, below, elig, eoi_clr, ack_set;
    logic [7:0] irr_next, isr_next;
    logic [2:0] lvl;
    logic       pend;

    // Only levels strictly above (numerically below) the highest-priority in-service level may nest.
    always_comb begin
        isr_low = isr & (~isr + 8'd1);
        below   = (isr == '0) ? '1 : (isr_low - 8'd1);
        elig    = irr & ~imr & below;
        pend    = (elig != '0);
        lvl     = '0;
        for (int unsigned i = 8; i > 0; i--) begin
            if (elig[i-1]) lvl = 3'(i - 1);
        end
    end

    assign intr = pend;

    always_comb begin
        eoi_clr = '0;
        ack_set = '0;
        if (cs && wr && a == 2'd0 && idata[7]) begin
            if (idata[6]) eoi_clr[idata[2:0]] = 1'b1;
            else          eoi_clr = isr_low;
        end
        if (inta && pend) ack_set[lvl] = 1'b1;
        // The acknowledge bit is applied after the EOI clear so it always survives.
        isr_next = (isr & ~eoi_clr) | ack_set;
        // A fresh edge re-latches a request even if acknowledged in the same cycle.
        irr_next = (irr & ~ack_set) | (irq & ~last_irq);
    end

    always_ff @(posedge clk) begin
        last_irq <= irq;
        if (reset) begin
            irr        <= '0;
            isr        <= '0;
            imr        <= '1;
            base       <= VEC_BASE;
            rsel       <= '0;
            ivec       <= '0;
            ivec_valid <= 1'b0;
        end else begin
            irr        <= irr_next;
            isr        <= isr_next;
            ivec_valid <= inta;
            if (inta) ivec <= pend ? {base, lvl} : {base, 3'b111};
            if (cs && wr) begin
                case (a)
                    2'd0: if (!idata[7]) rsel <= idata[1:0];
                    2'd1: imr <= idata;
                    2'd2: base <= idata[7:3];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        odata = '0;
        if (cs && rd) begin
            case (a)
                2'd0: begin
                    case (rsel)
                        2'd0:    odata = irr;
                        2'd1:    odata = isr;
                        2'd2:    odata = imr;
                        default: odata = '0;
                    endcase
                end
                2'd1:    odata = imr;
                2'd2:    odata = {base, 3'b000};
                default: odata = {pend, 4'b0000, lvl};
            endcase
        end
    end

endmodule
